// File: rtl/neuron_weight_ctrl_pkg.sv
// Shared types for the per-neuron weight sequencer.
// State encoding and config index field width.
package neuron_weight_ctrl_pkg;

  localparam int CFG_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/neuron_weight_ctrl.sv
// Per-neuron weight memory sequencer: config loads with auto-increment,
// one read per input sample, and sample/weight alignment for the MAC.
module neuron_weight_ctrl
  import neuron_weight_ctrl_pkg::*;
#(
  parameter int numWeight    = 784,
  parameter int neuronNo     = 0,
  parameter int layerNo      = 1,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int PRETRAINED   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CFG_IDX_W-1:0]    cfg_layer,
  input  logic [CFG_IDX_W-1:0]    cfg_neuron,
  input  logic [dataWidth-1:0]    cfg_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    wen,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic                    ren,
  output logic [addressWidth-1:0] radd,
  output logic [dataWidth-1:0]    x_out,
  output logic                    mul_valid,
  output logic                    mul_last,
  output logic                    loaded,
  output logic                    busy
);

  localparam logic [addressWidth-1:0] LAST =
    addressWidth'(numWeight - 1);
  localparam logic [CFG_IDX_W-1:0] MY_LAYER =
    CFG_IDX_W'(layerNo);
  localparam logic [CFG_IDX_W-1:0] MY_NEURON =
    CFG_IDX_W'(neuronNo);
  localparam bit PRE = (PRETRAINED != 0);

  state_t state;

  logic [addressWidth-1:0] wptr;
  logic [addressWidth-1:0] rptr;

  logic                 x_v1;
  logic                 x_l1;
  logic [dataWidth-1:0] x_d1;

  logic match;
  logic cfg_fire;
  logic in_fire;
  logic wr;
  logic w_last;
  logic r_last;
  logic in_wins;

  assign match = (cfg_layer == MY_LAYER) &&
                 (cfg_neuron == MY_NEURON);

  assign w_last = (wptr == LAST);
  assign r_last = (rptr == LAST);

  // A loaded idle neuron gives a pending sample priority over config
  assign in_wins = (state == IDLE) && in_valid &&
                   loaded && (wptr == '0);

  assign cfg_ready = ((state == IDLE) || (state == LOAD)) &&
                     !in_wins;

  assign in_ready = loaded && (wptr == '0) &&
                    ((state == IDLE) || (state == RUN));

  assign cfg_fire = cfg_valid && cfg_ready;
  assign in_fire  = in_valid && in_ready;
  assign wr       = cfg_fire && match && !PRE;

  assign busy = (state == RUN) || (state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wptr   <= '0;
      rptr   <= '0;
      loaded <= PRE;
    end else begin
      if (wr) begin
        wptr <= w_last ? '0 : wptr + 1'b1;
        if (w_last) loaded <= 1'b1;
      end
      if (in_fire) begin
        rptr <= r_last ? '0 : rptr + 1'b1;
      end
      case (state)
        IDLE: begin
          if (wr && !w_last)
            state <= LOAD;
          else if (in_fire)
            state <= r_last ? DRAIN : RUN;
        end
        LOAD: begin
          if (wr && w_last) state <= IDLE;
        end
        RUN: begin
          if (in_fire && r_last) state <= DRAIN;
        end
        DRAIN: begin
          if (mul_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage sample pipe lines x_out up with the memory read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen       <= 1'b0;
      wadd      <= '0;
      win       <= '0;
      ren       <= 1'b0;
      radd      <= '0;
      x_v1      <= 1'b0;
      x_l1      <= 1'b0;
      x_d1      <= '0;
      x_out     <= '0;
      mul_valid <= 1'b0;
      mul_last  <= 1'b0;
    end else begin
      wen <= wr;
      if (wr) begin
        wadd <= wptr;
        win  <= cfg_data;
      end
      ren <= in_fire;
      if (in_fire) begin
        radd <= rptr;
        x_d1 <= in_data;
      end
      x_v1      <= in_fire;
      x_l1      <= in_fire && r_last;
      x_out     <= x_d1;
      mul_valid <= x_v1;
      mul_last  <= x_l1;
    end
  end

endmodule

// File: tb/tb_neuron_weight_ctrl.sv
// Bench for neuron_weight_ctrl: loads, filtering, inference,
// arbitration, mid-frame reset and a preloaded-ROM instance.
module tb_neuron_weight_ctrl;

  localparam int NW = 3;
  localparam int AW = 10;
  localparam int DW = 16;

  typedef struct {
    int          cyc;
    logic [15:0] a;
    logic [15:0] d;
    logic        l;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  int pass_cnt = 0;
  int total = 0;

  ent_t q_w[$];
  ent_t q_r[$];
  ent_t q_m[$];
  ent_t q_p[$];

  logic          cfg_valid = 1'b0;
  logic          cfg_valid_p = 1'b0;
  logic [7:0]    cfg_layer = '0;
  logic [7:0]    cfg_neuron = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          in_valid = 1'b0;
  logic          in_valid_p = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          cfg_ready, in_ready, wen, ren;
  logic          mul_valid, mul_last, loaded, busy;
  logic [AW-1:0] wadd, radd;
  logic [DW-1:0] win, x_out;

  logic          cfg_ready_p, in_ready_p, wen_p, ren_p;
  logic          mul_valid_p, mul_last_p, loaded_p, busy_p;
  logic [AW-1:0] wadd_p, radd_p;
  logic [DW-1:0] win_p, x_out_p;

  neuron_weight_ctrl #(
    .numWeight(NW), .neuronNo(5), .layerNo(1),
    .addressWidth(AW), .dataWidth(DW), .PRETRAINED(0)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .wen(wen), .wadd(wadd), .win(win),
    .ren(ren), .radd(radd),
    .x_out(x_out), .mul_valid(mul_valid),
    .mul_last(mul_last), .loaded(loaded), .busy(busy)
  );

  neuron_weight_ctrl #(
    .numWeight(NW), .neuronNo(5), .layerNo(1),
    .addressWidth(AW), .dataWidth(DW), .PRETRAINED(1)
  ) dut_p (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid_p), .cfg_ready(cfg_ready_p),
    .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .cfg_data(cfg_data),
    .in_valid(in_valid_p), .in_ready(in_ready_p),
    .in_data(in_data),
    .wen(wen_p), .wadd(wadd_p), .win(win_p),
    .ren(ren_p), .radd(radd_p),
    .x_out(x_out_p), .mul_valid(mul_valid_p),
    .mul_last(mul_last_p), .loaded(loaded_p), .busy(busy_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for the main instance
  always @(negedge clk) begin
    ent_t e;
    if (mon_en && !rst) begin
      if (q_w.size() > 0 && q_w[0].cyc < cyc) begin
        total++;
        $display("FAIL wen_missing cyc=%0d want wadd=%0d win=%h at cyc %0d",
                 cyc, q_w[0].a, q_w[0].d, q_w[0].cyc);
        void'(q_w.pop_front());
      end
      if (q_r.size() > 0 && q_r[0].cyc < cyc) begin
        total++;
        $display("FAIL ren_missing cyc=%0d want radd=%0d at cyc %0d",
                 cyc, q_r[0].a, q_r[0].cyc);
        void'(q_r.pop_front());
      end
      if (q_m.size() > 0 && q_m[0].cyc < cyc) begin
        total++;
        $display("FAIL mul_missing cyc=%0d want x=%h at cyc %0d",
                 cyc, q_m[0].d, q_m[0].cyc);
        void'(q_m.pop_front());
      end
      if (wen === 1'b1) begin
        total++;
        if (q_w.size() == 0) begin
          $display("FAIL wen_unexpected cyc=%0d got wadd=%0d win=%h want no write",
                   cyc, wadd, win);
        end else begin
          e = q_w.pop_front();
          if (e.cyc != cyc || wadd !== e.a[AW-1:0] || win !== e.d)
            $display("FAIL wen_pulse got cyc=%0d wadd=%0d win=%h want cyc=%0d wadd=%0d win=%h",
                     cyc, wadd, win, e.cyc, e.a, e.d);
          else
            pass_cnt++;
        end
      end
      if (ren === 1'b1) begin
        total++;
        if (q_r.size() == 0) begin
          $display("FAIL ren_unexpected cyc=%0d got radd=%0d want no read",
                   cyc, radd);
        end else begin
          e = q_r.pop_front();
          if (e.cyc != cyc || radd !== e.a[AW-1:0])
            $display("FAIL ren_pulse got cyc=%0d radd=%0d want cyc=%0d radd=%0d",
                     cyc, radd, e.cyc, e.a);
          else
            pass_cnt++;
        end
      end
      if (mul_valid === 1'b1) begin
        total++;
        if (q_m.size() == 0) begin
          $display("FAIL mul_unexpected cyc=%0d got x=%h want no pair",
                   cyc, x_out);
        end else begin
          e = q_m.pop_front();
          if (e.cyc != cyc || x_out !== e.d || mul_last !== e.l)
            $display("FAIL mul_pair got cyc=%0d x=%h last=%b want cyc=%0d x=%h last=%b",
                     cyc, x_out, mul_last, e.cyc, e.d, e.l);
          else
            pass_cnt++;
        end
      end else if (mul_last === 1'b1) begin
        total++;
        $display("FAIL mul_last_alone cyc=%0d got last=1 want 0", cyc);
      end
    end
  end

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({wen, ren, mul_valid, mul_last, busy} !== 5'b0)
      $display("FAIL reset_ctrl got %b want 00000",
               {wen, ren, mul_valid, mul_last, busy});
    else pass_cnt++;
    total++;
    if ({wadd, win, radd, x_out} !== '0)
      $display("FAIL reset_data got %h %h %h %h want 0",
               wadd, win, radd, x_out);
    else pass_cnt++;
    total++;
    if (loaded !== 1'b0)
      $display("FAIL reset_loaded got %b want 0", loaded);
    else pass_cnt++;
    total++;
    if (loaded_p !== 1'b1)
      $display("FAIL reset_loaded_pre got %b want 1", loaded_p);
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if ({cfg_ready, in_ready} !== 2'b10)
      $display("FAIL reset_ready got %b want 10",
               {cfg_ready, in_ready});
    else pass_cnt++;
    mon_en = 1'b1;
  endtask

  task automatic test_load();
    logic [15:0] v[3];
    v[0] = 16'h0011;
    v[1] = 16'h0022;
    v[2] = 16'h0033;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cfg_valid  = 1'b1;
      cfg_layer  = 8'd1;
      cfg_neuron = 8'd5;
      cfg_data   = v[i];
      #1;
      total++;
      if (cfg_ready !== 1'b1)
        $display("FAIL load_ready word%0d got %b want 1", i, cfg_ready);
      else pass_cnt++;
      if (i == 2) begin
        total++;
        if (loaded !== 1'b0)
          $display("FAIL load_early got %b want 0", loaded);
        else pass_cnt++;
      end
      q_w.push_back('{cyc + 1, 16'(i), v[i], 1'b0});
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    #1;
    total++;
    if (loaded !== 1'b1)
      $display("FAIL load_done got %b want 1", loaded);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (q_w.size() != 0)
      $display("FAIL load_drain got %0d pending want 0", q_w.size());
    else pass_cnt++;
  endtask

  task automatic test_filter();
    logic [7:0] ly[4];
    logic [7:0] nr[4];
    ly[0] = 8'd1; nr[0] = 8'd4;
    ly[1] = 8'd2; nr[1] = 8'd5;
    ly[2] = 8'd2; nr[2] = 8'd4;
    ly[3] = 8'd1; nr[3] = 8'd6;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      cfg_valid  = 1'b1;
      cfg_layer  = ly[i];
      cfg_neuron = nr[i];
      cfg_data   = 16'hF0 + 16'(i);
      #1;
      total++;
      if (cfg_ready !== 1'b1)
        $display("FAIL filter_ready word%0d got %b want 1",
                 i, cfg_ready);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({loaded, busy, in_ready} !== 3'b101)
      $display("FAIL filter_state got %b want 101",
               {loaded, busy, in_ready});
    else pass_cnt++;
  endtask

  task automatic test_infer(input logic [15:0] v0,
                            input logic [15:0] v1,
                            input logic [15:0] v2);
    logic [15:0] v[3];
    v[0] = v0;
    v[1] = v1;
    v[2] = v2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      #1;
      total++;
      if (in_ready !== 1'b1)
        $display("FAIL infer_ready s%0d got %b want 1", i, in_ready);
      else pass_cnt++;
      if (i > 0) begin
        total++;
        if (busy !== 1'b1)
          $display("FAIL infer_busy s%0d got %b want 1", i, busy);
        else pass_cnt++;
      end
      q_r.push_back('{cyc + 1, 16'(i), 16'h0, 1'b0});
      q_m.push_back('{cyc + 2, 16'h0, v[i], i == 2});
      @(posedge clk);
      #1;
    end
    in_data = 16'h0099;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if ({in_ready, cfg_ready, busy} !== 3'b001)
        $display("FAIL drain_ready c%0d got %b want 001",
                 k, {in_ready, cfg_ready, busy});
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0)
      $display("FAIL infer_idle got busy=%b want 0", busy);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (q_r.size() + q_m.size() != 0)
      $display("FAIL infer_drain got %0d pending want 0",
               q_r.size() + q_m.size());
    else pass_cnt++;
  endtask

  task automatic test_arbitration();
    logic [15:0] v[3];
    v[0] = 16'h0007;
    v[1] = 16'h0008;
    v[2] = 16'h0009;
    @(posedge clk);
    #1;
    cfg_valid  = 1'b1;
    cfg_layer  = 8'd1;
    cfg_neuron = 8'd5;
    cfg_data   = 16'h0BAD;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      #1;
      total++;
      if ({in_ready, cfg_ready} !== 2'b10)
        $display("FAIL arb_run s%0d got %b want 10",
                 i, {in_ready, cfg_ready});
      else pass_cnt++;
      q_r.push_back('{cyc + 1, 16'(i), 16'h0, 1'b0});
      q_m.push_back('{cyc + 2, 16'h0, v[i], i == 2});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (cfg_ready !== 1'b0)
        $display("FAIL arb_drain c%0d got cfg_ready=%b want 0",
                 k, cfg_ready);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    #1;
    total++;
    if ({busy, cfg_ready} !== 2'b01)
      $display("FAIL arb_end got %b want 01", {busy, cfg_ready});
    else pass_cnt++;

    @(posedge clk);
    #1;
    cfg_valid = 1'b1;
    cfg_data  = 16'h0044;
    #1;
    total++;
    if (cfg_ready !== 1'b1)
      $display("FAIL reload_w0 got %b want 1", cfg_ready);
    else pass_cnt++;
    q_w.push_back('{cyc + 1, 16'd0, 16'h0044, 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 16'h0077;
    for (int i = 1; i < 3; i++) begin
      cfg_data = 16'h0044 + 16'(i * 16'h11);
      #1;
      total++;
      if ({in_ready, cfg_ready, loaded} !== 3'b011)
        $display("FAIL reload_block w%0d got %b want 011",
                 i, {in_ready, cfg_ready, loaded});
      else pass_cnt++;
      q_w.push_back('{cyc + 1, 16'(i), cfg_data, 1'b0});
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL reload_open got %b want 1", in_ready);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (q_w.size() + q_r.size() + q_m.size() != 0)
      $display("FAIL arb_pending got %0d want 0",
               q_w.size() + q_r.size() + q_m.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 16'h0001;
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL mid_ready got %b want 1", in_ready);
    else pass_cnt++;
    q_r.push_back('{cyc + 1, 16'd0, 16'h0, 1'b0});
    @(posedge clk);
    #1;
    in_data = 16'h0002;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    q_r.delete();
    q_m.delete();
    #1;
    total++;
    if ({wen, ren, mul_valid, mul_last, busy, loaded} !== 6'b0)
      $display("FAIL mid_rst_ctrl got %b want 000000",
               {wen, ren, mul_valid, mul_last, busy, loaded});
    else pass_cnt++;
    total++;
    if ({wadd, win, radd, x_out} !== '0)
      $display("FAIL mid_rst_data got %h %h %h %h want 0",
               wadd, win, radd, x_out);
    else pass_cnt++;
    total++;
    if (loaded_p !== 1'b1)
      $display("FAIL mid_rst_pre got %b want 1", loaded_p);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0005;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if ({in_ready, cfg_ready} !== 2'b01)
        $display("FAIL mid_refuse c%0d got %b want 01",
                 k, {in_ready, cfg_ready});
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_pretrained();
    ent_t e;
    @(posedge clk);
    #1;
    cfg_layer  = 8'd1;
    cfg_neuron = 8'd5;
    for (int i = 0; i < 4; i++) begin
      cfg_valid_p = (i < 3);
      cfg_data    = 16'h1230 + 16'(i);
      #1;
      if (i < 3) begin
        total++;
        if (cfg_ready_p !== 1'b1)
          $display("FAIL pre_ready w%0d got %b want 1", i, cfg_ready_p);
        else pass_cnt++;
      end
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (wen_p !== 1'b0)
          $display("FAIL pre_wen w%0d got %b want 0", i, wen_p);
        else pass_cnt++;
      end
      @(posedge clk);
      #1;
    end
    cfg_valid_p = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k < 3) begin
        in_valid_p = 1'b1;
        in_data    = 16'h0010 + 16'(k);
        #1;
        total++;
        if (in_ready_p !== 1'b1)
          $display("FAIL pre_in_ready s%0d got %b want 1", k, in_ready_p);
        else pass_cnt++;
        q_p.push_back('{cyc + 2, 16'h0, in_data, k == 2});
      end else begin
        in_valid_p = 1'b0;
      end
      @(negedge clk);
      total++;
      if (ren_p !== (k >= 1 && k <= 3) ||
          (ren_p === 1'b1 && radd_p !== AW'(k - 1)))
        $display("FAIL pre_ren k%0d got ren=%b radd=%0d want ren=%b radd=%0d",
                 k, ren_p, radd_p, (k >= 1 && k <= 3), k - 1);
      else pass_cnt++;
      if (mul_valid_p === 1'b1) begin
        total++;
        if (q_p.size() == 0) begin
          $display("FAIL pre_mul_unexpected k%0d got x=%h want none",
                   k, x_out_p);
        end else begin
          e = q_p.pop_front();
          if (e.cyc != cyc || x_out_p !== e.d || mul_last_p !== e.l)
            $display("FAIL pre_mul got cyc=%0d x=%h last=%b want cyc=%0d x=%h last=%b",
                     cyc, x_out_p, mul_last_p, e.cyc, e.d, e.l);
          else pass_cnt++;
        end
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (q_p.size() != 0 || busy_p !== 1'b0 || loaded_p !== 1'b1)
      $display("FAIL pre_end got pending=%0d busy=%b loaded=%b want 0 0 1",
               q_p.size(), busy_p, loaded_p);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_filter();
    test_infer(16'h0001, 16'h0002, 16'h0003);
    test_infer(16'h00A5, 16'h005A, 16'hFFFF);
    test_arbitration();
    test_reset_midframe();
    test_load();
    test_infer(16'h0001, 16'h0002, 16'h0003);
    test_pretrained();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/neuron_weight_ctrl.md
# neuron_weight_ctrl

Per-neuron sequencer for the neuron weight memory. It accepts weight-configuration writes and addresses them to its own memory with auto-increment. It also issues one memory read per accepted input sample during inference, and aligns each sample with the weight it reads. It arbitrates the two traffic types so that no weight load overlaps an inference frame, and it sits between the layer-level config/input fabric and one weight memory plus MAC.

## Interface
- `numWeight`, 784: weights per neuron; this is the frame length.
- `neuronNo`, 0: neuron index this instance answers to.
- `layerNo`, 1: layer index this instance answers to.
- `addressWidth`, 10: weight memory address width. Requires `numWeight <= 2**addressWidth`.
- `dataWidth`, 16: weight and input sample width.
- `PRETRAINED`, 0: 1 means the memory is a preloaded ROM. Config writes are accepted and dropped.

One clock; reset is asynchronous and active-high.

- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous active-high reset.
- `cfg_valid`, in, 1: config word offered.
- `cfg_ready`, out, 1: config word accepted when high together with `cfg_valid`.
- `cfg_layer`, in, 8: target layer of the config word.
- `cfg_neuron`, in, 8: target neuron of the config word.
- `cfg_data`, in, `dataWidth`: weight value.
- `in_valid`, in, 1: input sample offered.
- `in_ready`, out, 1: input sample accepted when high together with `in_valid`.
- `in_data`, in, `dataWidth`: input sample.
- `wen`, out, 1: memory write enable.
- `wadd`, out, `addressWidth`: memory write address.
- `win`, out, `dataWidth`: memory write data.
- `ren`, out, 1: memory read enable.
- `radd`, out, `addressWidth`: memory read address.
- `x_out`, out, `dataWidth`: sample aligned with the memory's `wout`.
- `mul_valid`, out, 1: `x_out` and `wout` form a valid pair.
- `mul_last`, out, 1: marks the last pair of a frame.
- `loaded`, out, 1: a full weight set is present.
- `busy`, out, 1: an inference frame is in flight.

## Operation
- States: IDLE, LOAD, RUN, DRAIN.
- Config word matches when `cfg_layer==layerNo` and `cfg_neuron==neuronNo`.
  - Non-matching words are accepted and ignored. `cfg_ready` is high and there is no `wen`.
- Write pointer `wptr`, 0..numWeight-1:
  - Each accepted matching word writes `win=cfg_data` at `wadd=wptr`, then increments `wptr`.
  - At `numWeight-1`, `wptr` wraps to 0, `loaded` is set, and the state returns to IDLE.
  - While `wptr!=0` the state is LOAD.
- Read pointer `rptr`, 0..numWeight-1:
  - Each accepted sample issues `ren` at `radd=rptr`, then increments `rptr`.
  - At `numWeight-1`, `rptr` wraps to 0 and the state moves to DRAIN.
- `cfg_ready` = state in {IDLE, LOAD}, and not (IDLE with `in_valid` and `loaded` and `wptr==0`).
- `in_ready` = `loaded`, and `wptr==0`, and state in {IDLE, RUN}.
- Arbitration:
  - IDLE with `cfg_valid` and `in_valid` both high, `wptr==0`, `loaded=1`: the input wins and RUN starts.
  - If `loaded=0`, the config word wins.
  - LOAD: input is always blocked, even if `loaded` is set from an earlier pass, so a partial reload is never read.
  - RUN/DRAIN: config is blocked until the frame ends.
- A reload over a loaded set overwrites in place. `loaded` stays 1; reads stay blocked until `wptr` wraps.
- DRAIN lasts until `mul_last` is emitted, then the state goes to IDLE. `busy` = state in {RUN, DRAIN}.
- `PRETRAINED=1`:
  - `loaded` resets to 1.
  - Matching words are accepted with `wen=0`.
  - `wptr` never moves and the state never enters LOAD.
- Gaps in `in_valid` during RUN are allowed. `rptr` holds.

## Timing
- Reset values:
  - Outputs: `wen`, `ren`, `mul_valid`, `mul_last`, `busy` = 0; `wadd`, `win`, `radd`, `x_out` = 0.
  - `loaded` = `PRETRAINED`.
  - Internal: `wptr`, `rptr` = 0; state = IDLE.
  - Reset mid-frame or mid-load discards everything. A partial load with `PRETRAINED=0` leaves `loaded=0`.
- `wen`/`wadd`/`win` are registered. `wen` is high exactly the cycle after the handshake, for one cycle.
- `ren`/`radd` are registered, one cycle after the handshake.
- Memory `wout` is valid one cycle after `ren`.
- `x_out`/`mul_valid`/`mul_last` are pipelined two cycles after the input handshake, matching `wout`.
- Throughput is one config word per cycle and one sample per cycle. Ready signals are combinational from state and pointers.
- State goes RUN to DRAIN on the cycle after the last handshake, and DRAIN to IDLE the cycle after `mul_last`.

## Structure
- Shared package holds:
  - the state encoding (IDLE/LOAD/RUN/DRAIN, 2 bits);
  - `CFG_IDX_W=8` for the config layer/neuron field widths.
- No sub-module. The weight memory stays a separate instance wired by the enclosing neuron.

## Test plan
- **Load:** `numWeight=3`, `layerNo=1`, `neuronNo=5`; send 3 matching words 0x0011, 0x0022, 0x0033.
  - Required: `wen` pulses at `wadd` 0, 1, 2 with those values.
  - Required: `loaded` rises the cycle after the third handshake.
- **Filtering:** interleave words for neuron 4 and layer 2.
  - Required: all are accepted (`cfg_ready=1`), no `wen`, `wptr` unchanged.
- **Inference:** after loading, send samples 1, 2, 3 back-to-back.
  - Required: `ren` at `radd` 0, 1, 2 on cycles t+1..t+3.
  - Required: `mul_valid` with `x_out`=1, 2, 3 on t+2..t+4; `mul_last` only with `x_out`=3.
  - Required: `busy` falls after DRAIN.
- **Arbitration:** `in_valid` and `cfg_valid` together.
  - When loaded and idle: the input wins and `cfg_ready` stays 0 through the whole frame.
  - After 1 of 3 reload words: `in_ready=0` until the reload completes.
- **Reset mid-frame:** assert `rst` after 2 of 3 samples.
  - Required: all outputs are 0 immediately, `loaded=0`, and the next sample is refused until a reload.
- **PRETRAINED=1:**
  - Required: `loaded=1` out of reset, matching words produce no `wen`, and inference runs without any load.
